// File: rtl/feather_pkg.sv
// rtl/feather_pkg.sv - shared types and constants for the fetch stage
package feather_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int INSTR_WIDTH = 32;
  localparam int CNT_WIDTH   = 16;
  localparam int PC_STEP     = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 8'h00;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register with redirect/step/hold next-PC mux
module fetch_pc_gen #(
  parameter int                    ADDR_WIDTH = feather_pkg::ADDR_WIDTH,
  parameter int                    PC_STEP    = feather_pkg::PC_STEP,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = feather_pkg::RESET_PC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;

  // Step wraps naturally modulo 2**ADDR_WIDTH; redirect wins over step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc_q <= redirect_pc_i;
    end else if (advance_i) begin
      pc_q <= pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID register, halt FSM and delivered count
module instruction_fetch #(
  parameter int                    ADDR_WIDTH  = feather_pkg::ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = feather_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = feather_pkg::RESET_PC,
  parameter int                    PC_STEP     = feather_pkg::PC_STEP,
  parameter int                    CNT_WIDTH   = feather_pkg::CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_instr_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  input  logic                   halt_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i,
  output logic                   halted_o,
  output logic [CNT_WIDTH-1:0]   fetch_count_o
);

  import feather_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  transfer;
  logic                  load;

  fetch_pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_STEP    (PC_STEP),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .advance_i        (load),
    .pc_o             (pc_q)
  );

  assign transfer = valid_q && instr_ready_i;
  assign load     = (state_q == FETCH_RUN) && !halt_i && !redirect_valid_i
                    && (!valid_q || instr_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:    if (halt_i)  state_d = FETCH_HALTED;
      FETCH_HALTED: if (!halt_i) state_d = FETCH_RUN;
      default:      state_d = FETCH_RUN;
    endcase
  end

  // A redirect flushes the IF/ID slot but the instruction leaving it this
  // cycle (if any) is still delivered and counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (redirect_valid_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      instr_q    <= imem_instr_i;
      instr_pc_q <= pc_q;
    end else if (transfer) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (transfer && !(&count_q)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign halted_o      = (state_q == FETCH_HALTED);
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  function automatic logic [31:0] rd(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  // main DUT
  logic        rst, redir, halt, ready;
  logic [7:0]  rpc;
  logic [7:0]  a_addr, a_ipc;
  logic [31:0] a_imem, a_instr;
  logic        a_valid, a_halted;
  logic [15:0] a_cnt;

  assign a_imem = rd(a_addr);

  instruction_fetch u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_addr_o      (a_addr),
    .imem_instr_i     (a_imem),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .halt_i           (halt),
    .instr_valid_o    (a_valid),
    .instr_o          (a_instr),
    .instr_pc_o       (a_ipc),
    .instr_ready_i    (ready),
    .halted_o         (a_halted),
    .fetch_count_o    (a_cnt)
  );

  // wrap DUT and saturation DUT, free-running with ready=1
  logic        rst2;
  logic [7:0]  b_addr, b_ipc, c_addr, c_ipc;
  logic [31:0] b_imem, b_instr, c_imem, c_instr;
  logic        b_valid, b_halted, c_valid, c_halted;
  logic [15:0] b_cnt;
  logic [1:0]  c_cnt;

  assign b_imem = rd(b_addr);
  assign c_imem = rd(c_addr);

  instruction_fetch #(.RESET_PC(8'hFC)) u_wrap (
    .clk_i (clk), .rst_i (rst2), .imem_addr_o (b_addr), .imem_instr_i (b_imem),
    .redirect_valid_i (1'b0), .redirect_pc_i (8'h00), .halt_i (1'b0),
    .instr_valid_o (b_valid), .instr_o (b_instr), .instr_pc_o (b_ipc),
    .instr_ready_i (1'b1), .halted_o (b_halted), .fetch_count_o (b_cnt)
  );

  instruction_fetch #(.CNT_WIDTH(2)) u_sat (
    .clk_i (clk), .rst_i (rst2), .imem_addr_o (c_addr), .imem_instr_i (c_imem),
    .redirect_valid_i (1'b0), .redirect_pc_i (8'h00), .halt_i (1'b0),
    .instr_valid_o (c_valid), .instr_o (c_instr), .instr_pc_o (c_ipc),
    .instr_ready_i (1'b1), .halted_o (c_halted), .fetch_count_o (c_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst, ready, halt, redir;
    logic [7:0]  rpc;
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic [15:0] cnt;
    logic [7:0]  addr;
    logic        halted;
  } vec_t;

  vec_t tbl [17];

  // reference model state
  logic [7:0]  m_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid, m_halted;
  logic [15:0] m_cnt;

  task automatic m_step();
    logic xfer, ld;
    xfer = m_valid && ready;
    ld   = !m_halted && !halt && !redir && (!m_valid || ready);
    if (rst) begin
      m_pc = 8'h00; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_halted = 0;
    end else begin
      if (xfer && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (redir) begin
        m_valid = 0;
        m_pc    = rpc;
      end else if (ld) begin
        m_instr = rd(m_pc);
        m_ipc   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 8'd4;
      end else if (xfer) begin
        m_valid = 0;
      end
      m_halted = halt;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) mem[w*4 + b] = 8'(8'h11 * (w + 1));

    //          rst ready halt redir rpc     valid instr         ipc    cnt addr   halted
    tbl[0]  = '{0, 1, 0, 0, 8'h00, 1, 32'h11111111, 8'h00, 16'd0, 8'h04, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'h00, 1, 32'h22222222, 8'h04, 16'd1, 8'h08, 0};
    tbl[2]  = '{0, 0, 0, 0, 8'h00, 1, 32'h22222222, 8'h04, 16'd1, 8'h08, 0};
    tbl[3]  = '{0, 0, 0, 0, 8'h00, 1, 32'h22222222, 8'h04, 16'd1, 8'h08, 0};
    tbl[4]  = '{0, 0, 0, 0, 8'h00, 1, 32'h22222222, 8'h04, 16'd1, 8'h08, 0};
    tbl[5]  = '{0, 1, 0, 1, 8'h08, 0, 32'h0,        8'h00, 16'd2, 8'h08, 0};
    tbl[6]  = '{0, 1, 0, 0, 8'h00, 1, 32'h33333333, 8'h08, 16'd2, 8'h0C, 0};
    tbl[7]  = '{0, 1, 0, 0, 8'h00, 1, 32'h44444444, 8'h0C, 16'd3, 8'h10, 0};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 1, 32'h44444444, 8'h0C, 16'd3, 8'h10, 1};
    tbl[9]  = '{0, 0, 1, 0, 8'h00, 1, 32'h44444444, 8'h0C, 16'd3, 8'h10, 1};
    tbl[10] = '{0, 1, 1, 0, 8'h00, 0, 32'h0,        8'h00, 16'd4, 8'h10, 1};
    tbl[11] = '{0, 1, 0, 0, 8'h00, 0, 32'h0,        8'h00, 16'd4, 8'h10, 0};
    tbl[12] = '{0, 1, 0, 0, 8'h00, 1, rd(8'h10),    8'h10, 16'd4, 8'h14, 0};
    tbl[13] = '{0, 1, 1, 1, 8'h00, 0, 32'h0,        8'h00, 16'd5, 8'h00, 1};
    tbl[14] = '{0, 1, 0, 0, 8'h00, 0, 32'h0,        8'h00, 16'd5, 8'h00, 0};
    tbl[15] = '{0, 1, 0, 0, 8'h00, 1, 32'h11111111, 8'h00, 16'd5, 8'h04, 0};
    tbl[16] = '{1, 1, 0, 1, 8'h40, 0, 32'h0,        8'h00, 16'd0, 8'h00, 0};

    rst = 1; rst2 = 1; redir = 0; halt = 0; ready = 0; rpc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  32'(a_valid),  32'd0);
    chk("reset_instr",  a_instr,       32'd0);
    chk("reset_ipc",    32'(a_ipc),    32'd0);
    chk("reset_cnt",    32'(a_cnt),    32'd0);
    chk("reset_addr",   32'(a_addr),   32'h00);
    chk("reset_halted", 32'(a_halted), 32'd0);
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; ready = tbl[i].ready; halt = tbl[i].halt;
      redir = tbl[i].redir; rpc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(tbl[i].valid));
      if (tbl[i].valid || tbl[i].rst) begin
        chk($sformatf("vec%0d_instr", i), a_instr, tbl[i].instr);
        chk($sformatf("vec%0d_ipc", i), 32'(a_ipc), 32'(tbl[i].ipc));
      end
      chk($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_addr", i), 32'(a_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_halted", i), 32'(a_halted), 32'(tbl[i].halted));
    end

    // random phase; DUT is in reset state after the last vector
    m_pc = 8'h00; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_halted = 0;
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      ready = ($urandom_range(0, 9) < 7);
      halt  = ($urandom_range(0, 99) < 15);
      redir = ($urandom_range(0, 99) < 10);
      rpc   = 8'($urandom);
      m_step();
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_valid", i), 32'(a_valid), 32'(m_valid));
      if (m_valid) begin
        chk($sformatf("rnd%0d_instr", i), a_instr, m_instr);
        chk($sformatf("rnd%0d_ipc", i), 32'(a_ipc), 32'(m_ipc));
      end
      chk($sformatf("rnd%0d_cnt", i), 32'(a_cnt), 32'(m_cnt));
      chk($sformatf("rnd%0d_addr", i), 32'(a_addr), 32'(m_pc));
      chk($sformatf("rnd%0d_halted", i), 32'(a_halted), 32'(m_halted));
    end
    rst = 0; redir = 0; halt = 0; ready = 0;

    // wrap from 0xFC and 2-bit counter saturation
    #1;
    chk("wrap_reset_addr", 32'(b_addr), 32'hFC);
    rst2 = 0;
    for (int n = 1; n <= 6; n++) begin
      logic [7:0] exp_pc;
      @(posedge clk);
      #1;
      exp_pc = 8'hFC + 8'(4 * (n - 1));
      if (n <= 3) begin
        chk($sformatf("wrap%0d_valid", n), 32'(b_valid), 32'd1);
        chk($sformatf("wrap%0d_ipc", n), 32'(b_ipc), 32'(exp_pc));
        chk($sformatf("wrap%0d_instr", n), b_instr, rd(exp_pc));
      end
      chk($sformatf("sat%0d_cnt", n), 32'(c_cnt), (n - 1 < 3) ? 32'(n - 1) : 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
